// File: rtl/lfsr_rng.sv
// lfsr_rng: Fibonacci LFSR with a bounded random-draw engine.
// A draw masks the LFSR state to the smallest 2^k-1 covering the bound and
// retries on rejection; after MAX_RETRY rejections it folds the candidate
// back into range by subtracting (bound+1).
// Optional macro: LFSR_RNG_ZERO_GUARD_EN -- an all-zero state (only reachable
// by loading zero) is replaced by SEED on the next edge unless reloaded.
module lfsr_rng #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter int unsigned      MAX_RETRY = 4
) (
  input  logic             clk,
  input  logic             iReset,
  input  logic             iEnable,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iSeed,
  input  logic             iReq,
  input  logic [WIDTH-1:0] iMax,
  output logic [WIDTH-1:0] oState,
  output logic [WIDTH-1:0] oValue,
  output logic             oValid,
  output logic             oBusy
);

  localparam int unsigned RETRY_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     lfsr_q, lfsr_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 feedback;
  logic [WIDTH-1:0]     lfsr_step;
  logic [WIDTH-1:0]     cand;

  // Smallest all-ones value >= x: smear the highest set bit downwards.
  function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] m;
    m = x;
    for (int unsigned s = 1; s < WIDTH; s = s << 1) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

  assign feedback  = ^(lfsr_q & TAPS);
  assign lfsr_step = {lfsr_q[WIDTH-2:0], feedback};
  assign cand      = lfsr_q & mask_q;

  // LFSR next state: load beats (optional zero recovery) beats step beats hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (iLoad) begin
      lfsr_d = iSeed;
    end
`ifdef LFSR_RNG_ZERO_GUARD_EN
    else if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end
`endif
    else if (iEnable || (state_q == DRAW)) begin
      lfsr_d = lfsr_step;
    end
  end

  // Draw FSM next state and registered-output next values.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    max_d   = max_q;
    mask_d  = mask_q;
    value_d = value_q;
    case (state_q)
      IDLE: begin
        if (iReq) begin
          state_d = DRAW;
          max_d   = iMax;
          mask_d  = smear(iMax);
          retry_d = '0;
        end
      end
      DRAW: begin
        if (cand <= max_q) begin
          value_d = cand;
          state_d = DONE;
        end else if ((32'(retry_q) + 32'd1) < MAX_RETRY) begin
          retry_d = retry_q + RETRY_W'(1);
        end else begin
          // mask <= 2*max+1, so the folded value always lands in [0, max]
          value_d = WIDTH'({1'b0, cand} - {1'b0, max_q} - (WIDTH+1)'(1));
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      max_q   <= '0;
      mask_q  <= '0;
      value_q <= '0;
      retry_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      max_q   <= max_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      retry_q <= retry_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign oState = lfsr_q;
  assign oValue = value_q;
  assign oValid = valid_q;
  assign oBusy  = busy_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: randomized self-checking bench for lfsr_rng (default parameters).
// A transaction-level reference model tracks the LFSR value and the pending
// draw (bound, mask, attempt count) and predicts every output each cycle.
`timescale 1ns/1ps
module tb_lfsr_rng;

  localparam int unsigned MAX_RETRY = 4;
  localparam logic [15:0] SEED      = 16'h0001;
  localparam logic [15:0] TAPS      = 16'hB400;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] seed;
  logic        req;
  logic [15:0] max_v;
  logic [15:0] state;
  logic [15:0] value;
  logic        valid;
  logic        busy;

  int n_checks;
  int n_bad;

  // reference model
  logic [15:0] m_state, m_value, m_max, m_mask;
  bit          m_valid, m_busy, m_draw, m_done;
  int          m_tries;

  lfsr_rng dut (
    .clk     (clk),
    .iReset  (rst),
    .iEnable (enable),
    .iLoad   (load),
    .iSeed   (seed),
    .iReq    (req),
    .iMax    (max_v),
    .oState  (state),
    .oValue  (value),
    .oValid  (valid),
    .oBusy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] step_of(input logic [15:0] s);
    int unsigned fb;
    fb = $countones(s & TAPS) % 2;
    return 16'((32'(s) << 1) | fb);
  endfunction

  function automatic logic [15:0] mask_of(input logic [15:0] mx);
    int unsigned m;
    m = 0;
    while (m < 32'(mx)) m = m * 2 + 1;
    return 16'(m);
  endfunction

  task automatic model_reset();
    m_state = SEED; m_value = '0; m_max = '0; m_mask = '0;
    m_valid = 0; m_busy = 0; m_draw = 0; m_done = 0; m_tries = 0;
  endtask

  // advance the model by one rising edge using the inputs the DUT sampled
  task automatic model_edge();
    logic [15:0] c, nxt;
    if (rst) begin
      model_reset();
      return;
    end
    c = m_state & m_mask;
    if (load) nxt = seed;
`ifdef LFSR_RNG_ZERO_GUARD_EN
    else if (m_state == 16'h0000) nxt = SEED;
`endif
    else if (enable || m_draw) nxt = step_of(m_state);
    else nxt = m_state;

    if (m_done) begin
      m_done = 0;
    end else if (m_draw) begin
      m_tries++;
      if (c <= m_max) begin
        m_value = c; m_draw = 0; m_done = 1;
      end else if (m_tries == MAX_RETRY) begin
        m_value = 16'(32'(c) - 32'(m_max) - 32'd1); m_draw = 0; m_done = 1;
      end
    end else if (req) begin
      m_draw = 1; m_tries = 0; m_max = max_v; m_mask = mask_of(max_v);
    end
    m_state = nxt;
    m_valid = m_done;
    m_busy  = m_draw || m_done;
  endtask

  task automatic cmp_model();
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("value", 32'(value), 32'(m_value));
    check_eq("valid", 32'(valid), 32'(m_valid));
    check_eq("busy",  32'(busy),  32'(m_busy));
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic clear_inputs();
    enable = 0; load = 0; seed = '0; req = 0; max_v = '0;
  endtask

  task automatic apply_reset();
    rst = 1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic rand_inputs();
    enable = 1'($urandom_range(0, 1));
    load   = ($urandom_range(0, 7) == 0);
    seed   = 16'($urandom_range(1, 65535));
  endtask

  // one draw from idle; returns edges from request drive to first oValid
  task automatic do_draw(input logic [15:0] mx, input bit rnd, output int lat);
    req = 1; max_v = mx;
    if (rnd) rand_inputs();
    cycle();
    req = 0; lat = 1;
    while (!valid && lat < 12) begin
      if (rnd) rand_inputs();
      cycle();
      lat++;
    end
    check_eq("valid_seen", 32'(valid), 32'd1);
    check_eq("lat_range", 32'(lat >= 2 && lat <= 1 + MAX_RETRY), 32'd1);
    check_eq("value_le_max", 32'(value <= mx), 32'd1);
    if (rnd) rand_inputs();
    cycle();
    check_eq("valid_width", 32'(valid), 32'd0);
    check_eq("idle_after", 32'(busy), 32'd0);
    clear_inputs();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, first, seen;
    logic [15:0] mx;
    n_checks = 0; n_bad = 0;
    apply_reset();

    // reset values
    check_eq("rst_state", 32'(state), 32'h0001);
    check_eq("rst_value", 32'(value), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_busy",  32'(busy),  32'h0);

    // single step from the seed
    enable = 1;
    cycle();
    check_eq("step1", 32'(state), 32'h0002);

    // full period: first return to 0x0001 at step 65535
    apply_reset();
    enable = 1; first = 0;
    for (int i = 1; i <= 65535; i++) begin
      cycle();
      if (state == 16'h0001 && first == 0) first = i;
    end
    check_eq("period", 32'(first), 32'd65535);
    clear_inputs();

    // bound 0: result 0 two edges later, request while busy ignored
    apply_reset();
    req = 1; max_v = 16'h0000;
    cycle();
    check_eq("z_busy1", 32'(busy), 32'd1);
    check_eq("z_valid1", 32'(valid), 32'd0);
    max_v = 16'h0005;
    cycle();
    check_eq("z_valid2", 32'(valid), 32'd1);
    check_eq("z_value", 32'(value), 32'd0);
    check_eq("z_busy2", 32'(busy), 32'd1);
    cycle();
    req = 0;
    check_eq("z_busy3", 32'(busy), 32'd0);
    check_eq("z_valid3", 32'(valid), 32'd0);
    cycle();
    check_eq("z_ignored", 32'(busy), 32'd0);

    // full-range bound: accepted on first attempt
    do_draw(16'hFFFF, 0, lat);
    check_eq("full_lat", 32'(lat), 32'd2);

    // load and request together: first candidate uses the loaded seed
    load = 1; seed = 16'h1234; req = 1; max_v = 16'h00FF;
    cycle();
    clear_inputs();
    cycle();
    check_eq("ldreq_valid", 32'(valid), 32'd1);
    check_eq("ldreq_value", 32'(value), 32'h0034);
    cycle();

    // load during DRAW: candidate still uses the pre-load state
    load = 1; seed = 16'h00F0;
    cycle();
    load = 0; req = 1; max_v = 16'h000F;
    cycle();
    req = 0; load = 1; seed = 16'h0005;
    cycle();
    load = 0;
    check_eq("ld_draw_value", 32'(value), 32'h0000);
    check_eq("ld_draw_state", 32'(state), 32'h0005);
    cycle();

    // 1000 draws with bound 5 under random reloads and enables
    for (int i = 0; i < 1000; i++) do_draw(16'h0005, 1, lat);

    // random bounds including edge values
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: mx = 16'h0000;
        1: mx = 16'hFFFF;
        2: mx = 16'(32'd1 << $urandom_range(0, 15));
        3: mx = 16'((32'd1 << $urandom_range(1, 16)) - 1);
        default: mx = 16'($urandom_range(0, 65535));
      endcase
      do_draw(mx, 1, lat);
    end

    // zero load: guard restores SEED, otherwise locks up
    apply_reset();
    enable = 1; load = 1; seed = 16'h0000;
    cycle();
    load = 0;
    check_eq("zero_loaded", 32'(state), 32'h0000);
    cycle();
`ifdef LFSR_RNG_ZERO_GUARD_EN
    check_eq("zero_guard", 32'(state), 32'h0001);
`else
    check_eq("zero_lock1", 32'(state), 32'h0000);
    cycle();
    check_eq("zero_lock2", 32'(state), 32'h0000);
`endif
    load = 1; seed = 16'h0000;
    cycle();
    seed = 16'h00AA;
    cycle();
    load = 0;
    check_eq("zero_reload", 32'(state), 32'h00AA);
    clear_inputs();

    // reset mid-draw aborts without a strobe
    apply_reset();
    req = 1; max_v = 16'h0003;
    cycle();
    req = 0;
    check_eq("abort_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1;
    model_reset();
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_state", 32'(state), 32'(SEED));
    check_eq("abort_valid", 32'(valid), 32'd0);
    #1;
    rst = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (valid) seen++;
    end
    check_eq("abort_no_valid", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
